rr_arb_mux: RTL and testbench

- Parametrised, registered N-channel arbitrated multiplexer; successor to the plain combinational 4:1 mux.
- Gathers N_CH valid/ready input channels onto one output stream.
- Uses round-robin arbitration and a single output register stage with full one-word-per-cycle throughput.
- Sits between multiple producers (e.g. per-lane sources) and one shared consumer.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/rr_grant.sv | 41 ++++
 rtl/rr_arb_mux.sv | 113 +++++++++++
 tb/tb_rr_arb_mux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: channel-index width helper and arbitration mode constants.
// ARB_MODE follows RR_ARB_MUX_FIXED_PRIO_EN so that benches can select the expected behaviour.
package arb_pkg;

    localparam int ARB_RR    = 32'sd0;
    localparam int ARB_FIXED = 32'sd1;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    localparam int ARB_MODE = ARB_FIXED;
`else
    localparam int ARB_MODE = ARB_RR;
`endif

    // Bits needed to index n items; never less than one so that a 2-entry index stays valid.
    function automatic int sel_width(input int n);
        int w;
        w = 32'sd1;
        for (int i = 1; i < 32; i++) begin
            if ((32'sd1 << i) < n) begin
                w = i + 32'sd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational rotating-priority grant: the first requester at or after ptr (with wrap-around) wins.
// Intended for reuse by other arbiters; ptr must be below N_CH.
module rr_grant
    import arb_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any_grant
);

    int idx;

    // Priority search starting at ptr; the first hit blocks all later candidates.
    always_comb begin
        grant     = {N_CH{1'b0}};
        grant_idx = {SEL_W{1'b0}};
        any_grant = 1'b0;
        idx       = 32'sd0;
        for (int off = 0; off < N_CH; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end else begin
                idx = idx;
            end
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
                any_grant  = 1'b1;
            end else begin
                any_grant = any_grant;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N-channel round-robin arbitrated mux with valid/ready handshakes on both sides.
// Define RR_ARB_MUX_FIXED_PRIO_EN to drop the rotation pointer and give channel 0 fixed priority.
module rr_arb_mux
    import arb_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = sel_width(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_sel_q,   out_sel_d;

    logic [N_CH-1:0]   grant_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic              any_grant_s;
    logic              load_en_s;
    logic              xfer_s;
    logic [SEL_W-1:0]  ptr_s;

    rr_grant #(
        .N_CH (N_CH)
    ) u_grant (
        .req       (in_valid),
        .ptr       (ptr_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    // Output slot can take a word when empty or being drained this cycle; reset blocks any handshake.
    always_comb begin
        load_en_s = !out_valid_q || out_ready;
        if (rst) begin
            in_ready = {N_CH{1'b0}};
            xfer_s   = 1'b0;
        end else begin
            in_ready = grant_s & {N_CH{load_en_s}};
            xfer_s   = load_en_s && any_grant_s;
        end
    end

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    assign ptr_s = {SEL_W{1'b0}};
`else
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Pointer moves just past the winner, and only when a transfer actually completes.
    always_comb begin
        if (xfer_s) begin
            ptr_d = (grant_idx_s == SEL_W'(N_CH - 1)) ? {SEL_W{1'b0}} : grant_idx_s + SEL_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Rotation pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= {SEL_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_s = ptr_q;
`endif

    // Next output word: load on transfer, go empty on an idle load slot, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(grant_idx_s)*DATA_W +: DATA_W];
            out_sel_d   = grant_idx_s;
        end else if (load_en_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            out_sel_q   <= {SEL_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomised and scenario bench for rr_arb_mux (N_CH=4, DATA_W=8) against a queue-free
// behavioural model that searches channels in wrap-around order with modulo arithmetic.
module tb_rr_arb_mux;
    import arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;

    int n_checks = 0;
    int n_errors = 0;
    int mode_v;

    int         m_ptr;
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;

    rr_arb_mux #(.N_CH(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        int start;
        start = (mode_v == ARB_FIXED) ? 0 : m_ptr;
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N] === 1'b1) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 0;
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int  g;
        bit  ld;
        #3;
        ld = !m_valid || out_ready;
        g  = model_grant(in_valid);
        exp_rdy = (!rst && ld && g >= 0) ? N'(1 << g) : '0;
        check("in_ready",  in_ready,  exp_rdy);
        check("out_valid", out_valid, m_valid);
        check("out_data",  out_data,  m_data);
        check("out_sel",   out_sel,   m_sel);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_sel   = g;
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_data_seq();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
    endtask

    initial begin
        logic [7:0] held_d;
        int         held_s;
        int         exp_s;
        mode_v    = ARB_MODE;
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();

        // First reset edge establishes known state; second is checked.
        @(posedge clk);
        #1;
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  8'h00);
        rst = 1'b0;

        // Single request on ch2.
        in_valid = 4'b0100;
        in_data[2*W +: W] = 8'hA5;
        step();
        check("single_data", out_data, 8'hA5);
        check("single_sel",  out_sel,  2);

        // Full rotation from ptr=3 with all channels valid.
        in_valid = 4'b1111;
        set_data_seq();
        for (int k = 0; k < 6; k++) begin
            step();
            exp_s = (mode_v == ARB_FIXED) ? 0 : (3 + k) % N;
            check("rot_sel",  out_sel,  exp_s);
            check("rot_data", out_data, 8'h10 + 8'(exp_s));
        end

        // Backpressure: word held, no grants, then drain without a bubble.
        held_d = out_data;
        held_s = out_sel;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_data",  out_data, held_d);
            check("bp_sel",   out_sel,  held_s);
            check("bp_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        step();
        exp_s = (mode_v == ARB_FIXED) ? 0 : (held_s + 1) % N;
        check("bp_release_valid", out_valid, 1'b1);
        check("bp_release_sel",   out_sel,   exp_s);

        // Wrap-around skip: bring ptr to 3, then request ch0 and ch1.
        in_valid = 4'b0100;
        step();
        in_valid = 4'b0011;
        step();
        check("wrap_first", out_sel, 0);
        step();
        exp_s = (mode_v == ARB_FIXED) ? 0 : 1;
        check("wrap_second", out_sel, exp_s);

        // Reset while a word is held.
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_valid", out_valid, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("midrst_first_sel", out_sel, 0);

        // Random traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            in_valid  = N'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
